ascon_permutation_ctrl: RTL and testbench
=========================================

Name: ascon_permutation_ctrl

Overview:
Iterative sequencer for the Ascon-p[rnd] permutation (NIST SP 800-232 Sec 3). It holds the 320-bit state in a register and applies UNROLL rounds per clock. Each round is constant addition, then substitution_layer, then linear diffusion layer. It accepts a state plus a round count over a valid/ready handshake and returns the permuted state over a second valid/ready handshake. It is the shared permutation engine that the AEAD/hash mode controllers call.

Parameters:
UNROLL, 1, rounds evaluated per clock cycle; legal values are 1, 2, 4; elaboration error otherwise.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  synchronous, active-high reset.
in_valid_i  input  1  request valid.
in_ready_o  output  1  engine can accept a request.
state_i  input  ascon_state_t (5x64)  input state S0..S4.
rounds_i  input  5  rnd, sampled on input handshake; legal range 1..16.
out_valid_o  output  1  result valid.
out_ready_i  input  1  consumer accepts result.
state_o  output  ascon_state_t (5x64)  permuted state.
err_o  output  1  qualifies out_valid_o; the request had an illegal rounds_i.
busy_o  output  1  FSM not in IDLE.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset value: IDLE, state register 0, round counter 0, err 0.
- Reset values of outputs: in_ready_o=1, out_valid_o=0, err_o=0, busy_o=0, state_o=0.
- in_ready_o = (fsm==IDLE). The block has no input buffering and never accepts while busy.
- Input handshake is in_valid_i & in_ready_o. On handshake:
  - Latch state_i.
  - Set round index i = 16 - rounds_i.
  - Legal rounds_i means 1 <= rounds_i <= 16 and rounds_i % UNROLL == 0. A legal request goes to RUN.
  - An illegal request latches state_i unchanged, sets err=1, and goes directly to DONE with 0 rounds applied.
- Round constants c[0..15] = 3c 2d 1e 0f f0 e1 d2 c3 b4 a5 96 87 78 69 5a 4b. Round i XORs c[i] into S2 bits [7:0] only.
- RUN: each cycle applies rounds i..i+UNROLL-1 to the register and adds UNROLL to i. When i+UNROLL == 16 the last round is written and the FSM moves to DONE.
- Latency: rounds_i/UNROLL cycles in RUN. out_valid_o first rises on the cycle after the final RUN cycle.
  - Example: UNROLL=1, rnd=12: handshake at edge 0, out_valid_o high after edge 12.
  - Example: rnd=8 with UNROLL=4 takes 2 cycles.
- DONE: out_valid_o=1 and state_o = register. state_o and err_o stay stable while out_valid_o & !out_ready_i (backpressure is held indefinitely).
- Output handshake out_valid_o & out_ready_i goes DONE -> IDLE and clears err. The next request can be accepted one cycle later; there is no same-cycle turnaround.
- state_o holds the last result in IDLE. It is only meaningful when out_valid_o=1.
- In_valid_i while busy is ignored: no latch, and the requester must hold the request.
- rst_i asserted in any state returns to the reset values on the next edge. An in-flight permutation is discarded, no output is produced, and no partial state is visible.
- rst_i has priority over a simultaneous input or output handshake.
- The round counter is 5 bits and never wraps. The RUN exit compare is exact, so rnd=16 starts at i=0.

Test Plan:
- Reset/idle: hold rst_i 2 cycles mid-RUN (rnd=12, 5 rounds done) -> next cycle in_ready_o=1, out_valid_o=0, busy_o=0, and no result is ever emitted for that request.
- Single round: state_i all zero, rounds_i=1, UNROLL=1 -> result after 1 cycle, equal to the golden model (x2 bit pattern 0x4b through sbox_eq and the linear layer); err_o=0.
- Full Ascon-p[12] and p[8]: 200 random states each, for UNROLL=1, 2, 4 -> state_o matches the software golden model. Measured latency is exactly 12/UNROLL and 8/UNROLL cycles respectively.
- Illegal rounds: rounds_i=0, then 17, then 6 with UNROLL=4 -> out_valid_o after 1 cycle, err_o=1, state_o==state_i bit-exact.
- Backpressure: out_ready_i=0 for 10 cycles after done -> out_valid_o stays 1, state_o/err_o are stable, and in_ready_o=0 even with in_valid_i=1. Raise out_ready_i -> IDLE next cycle, then a new request is accepted.
- Back-to-back: 3 queued requests with in_valid_i held high and out_ready_i=1 -> each accepted exactly once, in order. The gap from out handshake to next in handshake is exactly 1 cycle.

Source files
------------

// File: rtl/ascon_permutation_ctrl_pkg.sv
// Shared types for the Ascon permutation engine and the mode controllers that call it.
package ascon_permutation_ctrl_pkg;
  // Index w holds word Sw of the Ascon state (S0..S4).
  typedef logic [4:0][63:0] ascon_state_t;
endpackage

// File: rtl/ascon_permutation_ctrl.sv
// Iterative Ascon-p[rnd] engine: UNROLL rounds per clock over a 320-bit state register,
// with valid/ready handshakes on request and result.
module ascon_permutation_ctrl
  import ascon_permutation_ctrl_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  ascon_state_t state_i,
  input  logic [4:0]   rounds_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output ascon_state_t state_o,
  output logic         err_o,
  output logic         busy_o
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
      $error("ascon_permutation_ctrl: UNROLL must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         r_fsm, w_fsm_nxt;
  ascon_state_t r_state, w_state_nxt;
  logic [4:0]   r_idx, w_idx_nxt;
  logic         r_err, w_err_nxt;
  logic         w_legal;
  logic         w_last;
  ascon_state_t w_chain [UNROLL+1];

  function automatic logic [7:0] rc(input logic [3:0] i);
    case (i)
      4'd0:    rc = 8'h3c;
      4'd1:    rc = 8'h2d;
      4'd2:    rc = 8'h1e;
      4'd3:    rc = 8'h0f;
      4'd4:    rc = 8'hf0;
      4'd5:    rc = 8'he1;
      4'd6:    rc = 8'hd2;
      4'd7:    rc = 8'hc3;
      4'd8:    rc = 8'hb4;
      4'd9:    rc = 8'ha5;
      4'd10:   rc = 8'h96;
      4'd11:   rc = 8'h87;
      4'd12:   rc = 8'h78;
      4'd13:   rc = 8'h69;
      4'd14:   rc = 8'h5a;
      default: rc = 8'h4b;
    endcase
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One full round: constant addition, bitsliced 5-bit S-box, linear diffusion.
  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, rc(i)};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  // In RUN the index never exceeds 15, so the low four bits select the constant.
  assign w_chain[0] = r_state;
  generate
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
      assign w_chain[u+1] = ascon_round(w_chain[u], r_idx[3:0] + 4'(u));
    end
  endgenerate

  assign w_legal = (rounds_i != 5'd0) && (rounds_i <= 5'd16) &&
                   ((rounds_i & 5'(UNROLL - 1)) == 5'd0);
  assign w_last  = ((r_idx + 5'(UNROLL)) == 5'd16);

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    case (r_fsm)
      IDLE: begin
        if (in_valid_i) begin
          w_state_nxt = state_i;
          if (w_legal) begin
            w_idx_nxt = 5'd16 - rounds_i;
            w_err_nxt = 1'b0;
            w_fsm_nxt = RUN;
          end else begin
            // Illegal round count: hand the input straight back, flagged.
            w_idx_nxt = 5'd0;
            w_err_nxt = 1'b1;
            w_fsm_nxt = DONE;
          end
        end
      end
      RUN: begin
        w_state_nxt = w_chain[UNROLL];
        w_idx_nxt   = r_idx + 5'(UNROLL);
        if (w_last) begin
          w_fsm_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          w_err_nxt = 1'b0;
          w_fsm_nxt = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_idx   <= 5'd0;
      r_err   <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign in_ready_o  = (r_fsm == IDLE);
  assign out_valid_o = (r_fsm == DONE);
  assign busy_o      = (r_fsm != IDLE);
  assign state_o     = r_state;
  assign err_o       = r_err;

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// Bench for ascon_permutation_ctrl: three engines (UNROLL 1, 2, 4) against a table-based Ascon model.
module tb_ascon_permutation_ctrl;
  import ascon_permutation_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         err       [3];
  logic         busy      [3];
  logic [4:0]   rnds      [3];
  ascon_state_t st_in     [3];
  ascon_state_t st_out    [3];

  int checks   = 0;
  int failures = 0;

  logic [7:0] rc_tab [16] = '{8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
                              8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
  logic [4:0] sbox_tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  always #5 clk = ~clk;

  ascon_permutation_ctrl #(.UNROLL(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .state_i(st_in[0]), .rounds_i(rnds[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .state_o(st_out[0]), .err_o(err[0]), .busy_o(busy[0]));
  ascon_permutation_ctrl #(.UNROLL(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .state_i(st_in[1]), .rounds_i(rnds[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .state_o(st_out[1]), .err_o(err[1]), .busy_o(busy[1]));
  ascon_permutation_ctrl #(.UNROLL(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .state_i(st_in[2]), .rounds_i(rnds[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .state_o(st_out[2]), .err_o(err[2]), .busy_o(busy[2]));

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference Ascon-p: S-box applied column by column through the 32-entry table.
  function automatic ascon_state_t model_perm(input ascon_state_t s_in, input int rnd);
    ascon_state_t s;
    logic [4:0] col, o;
    s = s_in;
    for (int r = 16 - rnd; r < 16; r++) begin
      s[2][7:0] = s[2][7:0] ^ rc_tab[r];
      for (int b = 0; b < 64; b++) begin
        col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        o = sbox_tab[col];
        s[0][b] = o[4]; s[1][b] = o[3]; s[2][b] = o[2]; s[3][b] = o[1]; s[4][b] = o[0];
      end
      s[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
      s[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
      s[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
      s[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
      s[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
    end
    return s;
  endfunction

  function automatic ascon_state_t rand_state();
    ascon_state_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at #1 after an edge with engine k idle; returns at #1 after the handshake edge.
  task automatic send(input int k, input ascon_state_t s, input logic [4:0] r);
    chk_int("in_ready_before_send", int'(in_ready[k]), 1);
    in_valid[k] = 1'b1;
    st_in[k]    = s;
    rnds[k]     = r;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid[k]) break;
    end
    if (!out_valid[k]) chk_int("out_valid_timeout", 0, 1);
  endtask

  task automatic take(input int k, output ascon_state_t res, output logic e);
    res = st_out[k];
    e   = err[k];
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic run_req(input int k, input ascon_state_t s, input logic [4:0] r,
                         output int lat, output ascon_state_t res, output logic e);
    send(k, s, r);
    wait_out(k, lat);
    take(k, res, e);
  endtask

  typedef struct {
    int         k;
    logic [4:0] rnd;
    bit         zero;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vq[$];

  initial begin
    int           lat;
    ascon_state_t s, s2, res, held, pres;
    logic         e, held_err;
    bit           seen;
    int           j_in, j_out, last_out, cyc;
    logic         pin, pout;
    ascon_state_t q_s [3];
    int           q_r [3];
    int           unr [3];

    unr = '{1, 2, 4};
    vq.push_back('{0, 5'd1,  1'b1, 1'b0, 1});
    vq.push_back('{0, 5'd12, 1'b0, 1'b0, 12});
    vq.push_back('{0, 5'd8,  1'b0, 1'b0, 8});
    vq.push_back('{0, 5'd16, 1'b0, 1'b0, 16});
    vq.push_back('{0, 5'd0,  1'b0, 1'b1, 1});
    vq.push_back('{0, 5'd31, 1'b0, 1'b1, 1});
    vq.push_back('{1, 5'd12, 1'b0, 1'b0, 6});
    vq.push_back('{1, 5'd8,  1'b0, 1'b0, 4});
    vq.push_back('{1, 5'd3,  1'b0, 1'b1, 1});
    vq.push_back('{1, 5'd16, 1'b0, 1'b0, 8});
    vq.push_back('{2, 5'd12, 1'b0, 1'b0, 3});
    vq.push_back('{2, 5'd8,  1'b0, 1'b0, 2});
    vq.push_back('{2, 5'd4,  1'b1, 1'b0, 1});
    vq.push_back('{2, 5'd16, 1'b0, 1'b0, 4});
    vq.push_back('{2, 5'd0,  1'b0, 1'b1, 1});
    vq.push_back('{2, 5'd17, 1'b0, 1'b1, 1});
    vq.push_back('{2, 5'd6,  1'b0, 1'b1, 1});

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; rnds[k] = 5'd0; st_in[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      chk_int("reset_in_ready", int'(in_ready[k]), 1);
      chk_int("reset_out_valid", int'(out_valid[k]), 0);
      chk_int("reset_err", int'(err[k]), 0);
      chk_int("reset_busy", int'(busy[k]), 0);
      chk("reset_state", st_out[k], '0);
    end

    foreach (vq[v]) begin
      s = vq[v].zero ? '0 : rand_state();
      run_req(vq[v].k, s, vq[v].rnd, lat, res, e);
      chk_int("vec_latency", lat, vq[v].exp_lat);
      chk_int("vec_err", int'(e), int'(vq[v].exp_err));
      chk("vec_state", res, vq[v].exp_err ? s : model_perm(s, int'(vq[v].rnd)));
    end

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 400; n++) begin
        int r;
        r = (n < 200) ? 12 : 8;
        s = rand_state();
        run_req(k, s, 5'(r), lat, res, e);
        chk_int("rand_latency", lat, r / unr[k]);
        chk_int("rand_err", int'(e), 0);
        chk("rand_state", res, model_perm(s, r));
      end
    end

    // Backpressure on the UNROLL=2 engine with a competing request held on the input.
    s  = rand_state();
    s2 = rand_state();
    send(1, s, 5'd8);
    wait_out(1, lat);
    chk_int("bp_latency", lat, 4);
    held     = st_out[1];
    held_err = err[1];
    chk("bp_result", held, model_perm(s, 8));
    in_valid[1] = 1'b1; st_in[1] = s2; rnds[1] = 5'd8;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk_int("bp_out_valid", int'(out_valid[1]), 1);
      chk("bp_state_stable", st_out[1], held);
      chk_int("bp_err_stable", int'(err[1]), int'(held_err));
      chk_int("bp_in_ready", int'(in_ready[1]), 0);
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    chk_int("bp_release_out_valid", int'(out_valid[1]), 0);
    chk_int("bp_release_in_ready", int'(in_ready[1]), 1);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    chk_int("bp_next_accepted", int'(busy[1]), 1);
    wait_out(1, lat);
    chk_int("bp_next_latency", lat, 4);
    take(1, res, e);
    chk("bp_next_state", res, model_perm(s2, 8));

    // Reset in the middle of a 12-round run: five rounds done, then two reset cycles.
    send(0, rand_state(), 5'd12);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_int("midrst_in_ready", int'(in_ready[0]), 1);
    chk_int("midrst_out_valid", int'(out_valid[0]), 0);
    chk_int("midrst_busy", int'(busy[0]), 0);
    chk("midrst_state", st_out[0], '0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    chk_int("midrst_no_result", int'(seen), 0);

    // Three queued requests with in_valid held high and the consumer always ready.
    for (int j = 0; j < 3; j++) q_s[j] = rand_state();
    q_r = '{2, 1, 3};
    j_in = 0; j_out = 0; last_out = 0; cyc = 0;
    in_valid[0] = 1'b1; st_in[0] = q_s[0]; rnds[0] = 5'(q_r[0]); out_ready[0] = 1'b1;
    while (j_out < 3 && cyc < 300) begin
      pin  = in_valid[0] & in_ready[0];
      pout = out_valid[0] & out_ready[0];
      pres = st_out[0];
      @(posedge clk); #1;
      cyc++;
      if (pout) begin
        chk("b2b_state", pres, model_perm(q_s[j_out], q_r[j_out]));
        last_out = cyc;
        j_out++;
      end
      if (pin) begin
        if (j_in > 0) chk_int("b2b_gap", cyc - last_out, 1);
        j_in++;
        if (j_in < 3) begin
          st_in[0] = q_s[j_in];
          rnds[0]  = 5'(q_r[j_in]);
        end else begin
          in_valid[0] = 1'b0;
        end
      end
    end
    out_ready[0] = 1'b0;
    chk_int("b2b_accepted", j_in, 3);
    chk_int("b2b_results", j_out, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
